spi_peripheral: RTL and testbench

SPI_PERIPHERAL -- requirements
Module: spi_peripheral

---
 rtl/spi_regmap_pkg.sv | 22 ++
 rtl/spi_peripheral_if.sv | 10 +
 rtl/spi_sync.sv | 30 +++
 rtl/spi_peripheral.sv | 119 +++++++++++
 tb/tb_spi_peripheral.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/spi_regmap_pkg.sv
// Register map, frame geometry and FSM state type shared by the SPI
// peripheral and its testbench.
package spi_regmap_pkg;

  localparam logic [6:0] ADDR_EN_OUT_7_0  = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_15_8 = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_7_0  = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_15_8 = 7'h03;
  localparam logic [6:0] ADDR_PWM_DUTY    = 7'h04;

  localparam int FRAME_BITS = 16;

  // Bit counter saturates one past a full frame so over-long frames stay invalid.
  localparam logic [4:0] CNT_SAT = 5'd17;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_COMMIT
  } state_t;

endpackage

// File: rtl/spi_peripheral_if.sv
// SPI pin bundle (mode 0, write-only, no CIPO); the controller side
// drives, the peripheral side listens.
interface spi_peripheral_if;
  logic ncs;
  logic sclk;
  logic copi;

  modport master (output ncs, output sclk, output copi);
  modport slave  (input  ncs, input  sclk, input  copi);
endinterface

// File: rtl/spi_sync.sv
// Multi-stage synchronizer for one asynchronous pin, plus one extra delay
// flop so the parent can detect edges on the synchronized signal.
module spi_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic q_dly
);

  logic [STAGES-1:0] chain;

  // NOTE: non-blocking assignments so each stage takes the previous stage's
  // old value; blocking here would collapse the chain into a single flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= {STAGES{RESET_VAL}};
      q_dly <= RESET_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      q_dly <= chain[STAGES-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/spi_peripheral.sv
// Write-only SPI mode-0 peripheral: 16-bit frames {wr, addr[6:0], data[7:0]}
// update five 8-bit configuration registers, oversampled on clk.
module spi_peripheral
  import spi_regmap_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [6:0] MAX_ADDR    = 7'h04
) (
  input  logic                clk,
  input  logic                rst,
  spi_peripheral_if.slave     spi,
  output logic [7:0]          en_reg_out_7_0,
  output logic [7:0]          en_reg_out_15_8,
  output logic [7:0]          en_reg_pwm_7_0,
  output logic [7:0]          en_reg_pwm_15_8,
  output logic [7:0]          pwm_duty_cycle,
  output logic                txn_ok,
  output logic                txn_err
);

  logic ncs_s, ncs_d, sclk_s, sclk_d, copi_s, copi_d_unused;

  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst(rst), .d(spi.ncs), .q(ncs_s), .q_dly(ncs_d));
  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .d(spi.sclk), .q(sclk_s), .q_dly(sclk_d));
  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst(rst), .d(spi.copi), .q(copi_s), .q_dly(copi_d_unused));

  // After reset the ncs chain still holds its reset 1s; ignore falling edges
  // until that has flushed and ncs has actually been seen high.
  localparam int FLUSH_CYCLES = SYNC_STAGES + 1;
  localparam int FW           = $clog2(FLUSH_CYCLES + 1);

  logic [FW-1:0] flush_cnt;
  logic          armed;

  always_ff @(posedge clk) begin
    if (rst) begin
      flush_cnt <= '0;
      armed     <= 1'b0;
    end else if (flush_cnt != FW'(FLUSH_CYCLES)) begin
      flush_cnt <= flush_cnt + 1'b1;
    end else if (ncs_s && ncs_d) begin
      armed <= 1'b1;
    end
  end

  logic ncs_fall, ncs_rise, sclk_rise;
  assign ncs_fall  = armed & ~ncs_s & ncs_d;
  assign ncs_rise  = ncs_s & ~ncs_d;
  assign sclk_rise = sclk_s & ~sclk_d;

  state_t                state, next_state;
  logic [4:0]            bit_cnt;
  logic [FRAME_BITS-1:0] shreg;
  logic                  frame_valid;

  assign frame_valid = (bit_cnt == 5'(FRAME_BITS)) && shreg[15] && (shreg[14:8] <= MAX_ADDR);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    next_state = state;
    txn_ok     = 1'b0;
    txn_err    = 1'b0;
    unique case (state)
      ST_IDLE:   if (ncs_fall) next_state = ST_SHIFT;
      ST_SHIFT:  if (ncs_rise) next_state = ST_COMMIT;
      ST_COMMIT: begin
        next_state = ST_IDLE;
        txn_ok     = frame_valid;
        txn_err    = ~frame_valid;
      end
      default:   next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt         <= '0;
      shreg           <= '0;
      en_reg_out_7_0  <= 8'h00;
      en_reg_out_15_8 <= 8'h00;
      en_reg_pwm_7_0  <= 8'h00;
      en_reg_pwm_15_8 <= 8'h00;
      pwm_duty_cycle  <= 8'h00;
    end else begin
      unique case (state)
        ST_IDLE: if (ncs_fall) begin
          bit_cnt <= '0;
          shreg   <= '0;
        end
        // An sclk edge coinciding with the ncs release is not part of the frame.
        ST_SHIFT: if (sclk_rise && !ncs_rise) begin
          shreg   <= {shreg[FRAME_BITS-2:0], copi_s};
          bit_cnt <= (bit_cnt == CNT_SAT) ? CNT_SAT : bit_cnt + 5'd1;
        end
        ST_COMMIT: if (frame_valid) begin
          case (shreg[14:8])
            ADDR_EN_OUT_7_0:  en_reg_out_7_0  <= shreg[7:0];
            ADDR_EN_OUT_15_8: en_reg_out_15_8 <= shreg[7:0];
            ADDR_EN_PWM_7_0:  en_reg_pwm_7_0  <= shreg[7:0];
            ADDR_EN_PWM_15_8: en_reg_pwm_15_8 <= shreg[7:0];
            ADDR_PWM_DUTY:    pwm_duty_cycle  <= shreg[7:0];
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed testbench for spi_peripheral: bit-banged SPI frames with
// hand-computed register images and txn pulse counts.
module tb_spi_peripheral;

  logic clk = 1'b0;
  logic rst;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
  logic txn_ok, txn_err;

  spi_peripheral_if spi ();

  spi_peripheral #(.SYNC_STAGES(2), .MAX_ADDR(7'h04)) dut (
    .clk             (clk),
    .rst             (rst),
    .spi             (spi.slave),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .txn_ok          (txn_ok),
    .txn_err         (txn_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int ok_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;

  always @(negedge clk) begin
    if (txn_ok === 1'b1)  ok_cnt++;
    if (txn_err === 1'b1) err_cnt++;
    if (txn_ok === 1'b1 && txn_err === 1'b1) both_cnt++;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d mismatched=%0d", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  // Packed register image: {out_7_0, out_15_8, pwm_7_0, pwm_15_8, duty}.
  function automatic logic [39:0] regs_now();
    return {en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic shift_bits(input logic [16:0] word, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) begin
      spi.copi = word[i];
      tick(3);
      spi.sclk = 1'b1;
      tick(3);
      spi.sclk = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [16:0] word, input int nbits, input int gap);
    spi.ncs = 1'b0;
    tick(3);
    shift_bits(word, nbits);
    tick(3);
    spi.ncs = 1'b1;
    tick(gap);
  endtask

  task automatic test_reset();
    rst = 1'b1; spi.ncs = 1'b1; spi.sclk = 1'b0; spi.copi = 1'b0;
    tick(5);
    n_cmp++;
    if (regs_now() !== 40'h0) begin
      n_bad++; $display("FAIL reset_regs: got %h expected %h", regs_now(), 40'h0);
    end
    n_cmp++;
    if (txn_ok !== 1'b0 || txn_err !== 1'b0) begin
      n_bad++; $display("FAIL reset_pulses: got ok=%b err=%b expected 0 0", txn_ok, txn_err);
    end
    rst = 1'b0;
    tick(10);
  endtask

  task automatic test_single_write();
    int ok0 = ok_cnt, err0 = err_cnt;
    send_frame(17'h08055, 16, 10);
    n_cmp++;
    if (regs_now() !== 40'h55_00_00_00_00) begin
      n_bad++; $display("FAIL single_write_regs: got %h expected %h", regs_now(), 40'h55_00_00_00_00);
    end
    n_cmp++;
    if (ok_cnt - ok0 !== 1 || err_cnt - err0 !== 0) begin
      n_bad++; $display("FAIL single_write_pulses: got ok=%0d err=%0d expected 1 0", ok_cnt - ok0, err_cnt - err0);
    end
  endtask

  task automatic test_two_writes();
    int ok0 = ok_cnt, err0 = err_cnt;
    send_frame(17'h084FF, 16, 10);
    send_frame(17'h08280, 16, 10);
    n_cmp++;
    if (regs_now() !== 40'h55_00_80_00_FF) begin
      n_bad++; $display("FAIL two_writes_regs: got %h expected %h", regs_now(), 40'h55_00_80_00_FF);
    end
    n_cmp++;
    if (ok_cnt - ok0 !== 2 || err_cnt - err0 !== 0) begin
      n_bad++; $display("FAIL two_writes_pulses: got ok=%0d err=%0d expected 2 0", ok_cnt - ok0, err_cnt - err0);
    end
  endtask

  task automatic test_invalid();
    int ok0 = ok_cnt, err0 = err_cnt;
    send_frame(17'h00012, 16, 10);
    send_frame(17'h08512, 16, 10);
    n_cmp++;
    if (regs_now() !== 40'h55_00_80_00_FF) begin
      n_bad++; $display("FAIL invalid_regs: got %h expected %h", regs_now(), 40'h55_00_80_00_FF);
    end
    n_cmp++;
    if (ok_cnt - ok0 !== 0 || err_cnt - err0 !== 2) begin
      n_bad++; $display("FAIL invalid_pulses: got ok=%0d err=%0d expected 0 2", ok_cnt - ok0, err_cnt - err0);
    end
  endtask

  task automatic test_bad_length();
    int ok0 = ok_cnt, err0 = err_cnt;
    send_frame(17'h040D5, 15, 10);
    send_frame(17'h181AA, 17, 10);
    n_cmp++;
    if (en_reg_out_15_8 !== 8'h00) begin
      n_bad++; $display("FAIL bad_length_reg: got %h expected %h", en_reg_out_15_8, 8'h00);
    end
    n_cmp++;
    if (regs_now() !== 40'h55_00_80_00_FF) begin
      n_bad++; $display("FAIL bad_length_regs: got %h expected %h", regs_now(), 40'h55_00_80_00_FF);
    end
    n_cmp++;
    if (ok_cnt - ok0 !== 0 || err_cnt - err0 !== 2) begin
      n_bad++; $display("FAIL bad_length_pulses: got ok=%0d err=%0d expected 0 2", ok_cnt - ok0, err_cnt - err0);
    end
  endtask

  task automatic test_reset_abort();
    int ok0 = ok_cnt, err0 = err_cnt;
    spi.ncs = 1'b0;
    tick(3);
    shift_bits(17'h00083, 8);
    rst = 1'b1;
    tick(4);
    rst = 1'b0;
    // ncs is still low at reset release: sclk activity here must not start a frame.
    tick(6);
    shift_bits(17'h000FF, 4);
    tick(6);
    spi.ncs = 1'b1;
    tick(10);
    n_cmp++;
    if (ok_cnt - ok0 !== 0 || err_cnt - err0 !== 0) begin
      n_bad++; $display("FAIL abort_pulses: got ok=%0d err=%0d expected 0 0", ok_cnt - ok0, err_cnt - err0);
    end
    n_cmp++;
    if (regs_now() !== 40'h0) begin
      n_bad++; $display("FAIL abort_regs: got %h expected %h", regs_now(), 40'h0);
    end
    send_frame(17'h083C3, 16, 10);
    n_cmp++;
    if (regs_now() !== 40'h00_00_00_C3_00) begin
      n_bad++; $display("FAIL abort_retry_regs: got %h expected %h", regs_now(), 40'h00_00_00_C3_00);
    end
    n_cmp++;
    if (ok_cnt - ok0 !== 1 || err_cnt - err0 !== 0) begin
      n_bad++; $display("FAIL abort_retry_pulses: got ok=%0d err=%0d expected 1 0", ok_cnt - ok0, err_cnt - err0);
    end
  endtask

  task automatic test_back_to_back();
    int ok0 = ok_cnt, err0 = err_cnt;
    send_frame(17'h08011, 16, 4);
    send_frame(17'h08122, 16, 4);
    send_frame(17'h08233, 16, 4);
    send_frame(17'h08344, 16, 4);
    send_frame(17'h08499, 16, 10);
    n_cmp++;
    if (regs_now() !== 40'h11_22_33_44_99) begin
      n_bad++; $display("FAIL b2b_regs: got %h expected %h", regs_now(), 40'h11_22_33_44_99);
    end
    n_cmp++;
    if (ok_cnt - ok0 !== 5 || err_cnt - err0 !== 0) begin
      n_bad++; $display("FAIL b2b_pulses: got ok=%0d err=%0d expected 5 0", ok_cnt - ok0, err_cnt - err0);
    end
    n_cmp++;
    if (both_cnt !== 0) begin
      n_bad++; $display("FAIL ok_err_overlap: got %0d cycles expected 0", both_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_two_writes();
    test_invalid();
    test_bad_length();
    test_reset_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
